acc_requant: RTL
================

ACC_REQUANT -- requirements
Module: acc_requant

Interface
REQ-001 Parameter ACCUM_WIDTH, default 32: signed accumulator input width, matching the mac_unit accum_out width.
REQ-002 Parameter OUT_WIDTH, default 8: signed quantized output width, matching the mac_unit data_a width.
REQ-003 Parameter MULT_WIDTH, default 16: unsigned requant multiplier width.
REQ-004 Parameter SHIFT_WIDTH, default 6: right-shift amount width.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_valid  input  1  in_acc is valid.
REQ-009 in_ready  output  1  the block accepts a beat this cycle.
REQ-010 in_acc  input  ACCUM_WIDTH  signed accumulator, i.e. mac_unit accum_out.
REQ-011 cfg_mult  input  MULT_WIDTH  unsigned scale multiplier.
REQ-012 cfg_shift  input  SHIFT_WIDTH  arithmetic right shift, 0..47.
REQ-013 cfg_zp  input  OUT_WIDTH  signed output zero point.
REQ-014 cfg_relu  input  1  enables ReLU clamping.
REQ-015 out_valid  output  1  out_data is valid.
REQ-016 out_ready  input  1  downstream accepts the beat.
REQ-017 out_data  output  OUT_WIDTH  signed quantized result.
REQ-018 sat_clr  input  1  synchronous clear of sat_count.
REQ-019 sat_count  output  16  count of range-saturated output beats.

Function
REQ-020 A beat SHALL be accepted on a rising edge when in_valid && in_ready; the cfg_* inputs SHALL be sampled with the same beat, so mid-stream cfg changes affect only later beats.
REQ-021 Arithmetic, computed without overflow:
- p = in_acc * cfg_mult, 48-bit signed.
- r = (p + (cfg_shift ? 1<<(cfg_shift-1) : 0)) >>> cfg_shift, round half toward +inf, 49-bit intermediate.
- y = r + cfg_zp.
REQ-022 Clamping: out_data = clamp(y, -128, 127); when cfg_relu=1 the lower bound SHALL be cfg_zp instead of -128.
REQ-023 Pipeline: two register stages.
- S1 holds p, rounding constant, shift, zp, relu.
- S2 holds out_data and a sat bit.
REQ-024 Latency SHALL be exactly 2 cycles: a beat accepted at edge N drives out_valid high after edge N+1 when there is no stall.
REQ-025 Throughput SHALL be 1 beat/cycle while out_ready=1.
REQ-026 Backpressure rules:
- S2 advances when !out_valid || out_ready.
- S1 advances into S2 when S2 advances.
- in_ready = !s1_valid || S2 advances (combinational).
REQ-027 Data handshake rules:
- out_data SHALL be held stable while out_valid && !out_ready.
- No beat SHALL be lost, duplicated or reordered.
- At most 2 beats SHALL be in flight.
REQ-028 The sat bit SHALL be set when y falls outside [-128, 127]; a ReLU-only clamp SHALL NOT set it.
REQ-029 sat_count SHALL increment on each output transfer (out_valid && out_ready) whose sat bit is 1, and SHALL stick at 0xFFFF.
REQ-030 sat_clr SHALL zero sat_count and SHALL dominate a simultaneous increment.

Reset
REQ-031 While rst_n=0: s1_valid=0, out_valid=0, out_data=0, sat_count=0, in_ready=0.
REQ-032 in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-033 A reset mid-operation SHALL discard all in-flight beats, with no output of those beats afterward.

Structure
REQ-034 A shared package SHALL hold ACCUM_WIDTH, OUT_WIDTH, QMIN=-128, QMAX=127, and the typedefs acc_t (signed 32) and q_t (signed 8); mac_unit's users share the same package.
REQ-035 One combinational sub-module, requant_sat, SHALL implement the shift, round, zero-point add, clamp and sat flag, instantiated once between S1 and S2.

Verification
REQ-036 Pass-through: acc=25, mult=1, shift=0, zp=0 -> out_data=25, out_valid rising exactly 2 cycles after accept, sat_count=0.
REQ-037 Rounding:
- acc=16129, mult=1, shift=7 -> 126.
- acc=3, shift=1 -> 2.
- acc=-3, shift=1 -> -1.
- acc=1, mult=3, shift=1 -> 2.
REQ-038 Saturation: acc=-200 then acc=1000 (mult=1, shift=0) -> -128 then 127; sat_count=2; pulsing sat_clr in the same cycle as a third saturating transfer -> sat_count=0.
REQ-039 ReLU: acc=-50, mult=1, shift=0, zp=10, relu=1 -> out_data=10, sat_count unchanged; with relu=0 -> -40.
REQ-040 Backpressure: stream 1,2,3,4 with out_ready=0 for 4 cycles -> in_ready=0 after 2 beats are held; out_data stable; outputs 1,2,3,4 in order once released.
REQ-041 Reset mid-stream: assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately; after release no stale beat appears and the next beat (acc=7) -> 7.

Source files
------------

// File: rtl/acc_requant_pkg.sv
// Shared widths, quantization bounds and scalar types for the accumulator
// requantization path (also used by mac_unit consumers).
package acc_requant_pkg;

  localparam int ACCUM_WIDTH   = 32;
  localparam int OUT_WIDTH     = 8;
  localparam int MULT_WIDTH    = 16;
  localparam int SHIFT_WIDTH   = 6;
  localparam int SAT_CNT_WIDTH = 16;

  localparam int QMIN = -128;
  localparam int QMAX = 127;

  typedef logic signed [ACCUM_WIDTH-1:0] acc_t;
  typedef logic signed [OUT_WIDTH-1:0]   q_t;

endpackage

// File: rtl/acc_requant_sat.sv
// requant_sat: combinational shift / round / zero-point / clamp stage.
//   i_p      signed scaled accumulator (acc * mult)
//   i_rnd    rounding constant, 1 << (shift-1) or 0 when shift is 0
//   i_shift  arithmetic right-shift amount
//   i_zp     signed output zero point
//   i_relu   raises the lower clamp bound to the zero point
//   o_data   clamped signed result
//   o_sat    result fell outside [QMIN, QMAX] before clamping
module requant_sat #(
  parameter int OUT_WIDTH   = 8,
  parameter int P_WIDTH     = 48,
  parameter int SHIFT_WIDTH = 6,
  parameter int QMIN        = -128,
  parameter int QMAX        = 127
) (
  input  logic signed [P_WIDTH-1:0]   i_p,
  input  logic        [P_WIDTH-1:0]   i_rnd,
  input  logic        [SHIFT_WIDTH-1:0] i_shift,
  input  logic signed [OUT_WIDTH-1:0] i_zp,
  input  logic                        i_relu,
  output logic signed [OUT_WIDTH-1:0] o_data,
  output logic                        o_sat
);

  // Two guard bits over the product: one for the rounding add, one for the
  // zero-point add, so nothing here can overflow.
  localparam int Y_WIDTH = P_WIDTH + 2;

  logic signed [P_WIDTH:0]   w_sum;
  logic signed [P_WIDTH:0]   w_r;
  logic signed [Y_WIDTH-1:0] w_y;
  logic signed [Y_WIDTH-1:0] w_zp;
  logic signed [Y_WIDTH-1:0] w_min;
  logic signed [Y_WIDTH-1:0] w_hi;
  logic signed [Y_WIDTH-1:0] w_lo;

  always_comb begin
    w_sum = $signed({i_p[P_WIDTH-1], i_p}) + $signed({1'b0, i_rnd});
    w_r   = w_sum >>> i_shift;
    w_zp  = $signed({{(Y_WIDTH-OUT_WIDTH){i_zp[OUT_WIDTH-1]}}, i_zp});
    w_y   = $signed({w_r[P_WIDTH], w_r}) + w_zp;
    w_min = Y_WIDTH'(QMIN);
    w_hi  = Y_WIDTH'(QMAX);
    w_lo  = i_relu ? w_zp : w_min;

    // Saturation is judged against the full range only; a ReLU clamp
    // inside that range is not a saturation event.
    o_sat = (w_y < w_min) || (w_y > w_hi);

    if (w_y > w_hi) begin
      o_data = w_hi[OUT_WIDTH-1:0];
    end else if (w_y < w_lo) begin
      o_data = w_lo[OUT_WIDTH-1:0];
    end else begin
      o_data = w_y[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/acc_requant.sv
// acc_requant: two-stage requantizer from a wide signed accumulator to a
// signed quantized output, with valid/ready handshakes on both sides and a
// sticky saturation counter.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake for in_acc and cfg_* (sampled together)
//   in_acc               signed accumulator
//   cfg_mult/shift/zp    scale multiplier, right shift, output zero point
//   cfg_relu             clamp lower bound to the zero point
//   out_valid/out_ready  output handshake for out_data
//   out_data             signed quantized result
//   sat_clr, sat_count   synchronous clear / count of saturated output beats
module acc_requant
  import acc_requant_pkg::*;
#(
  parameter int ACCUM_WIDTH = acc_requant_pkg::ACCUM_WIDTH,
  parameter int OUT_WIDTH   = acc_requant_pkg::OUT_WIDTH,
  parameter int MULT_WIDTH  = acc_requant_pkg::MULT_WIDTH,
  parameter int SHIFT_WIDTH = acc_requant_pkg::SHIFT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ACCUM_WIDTH-1:0]   in_acc,
  input  logic [MULT_WIDTH-1:0]    cfg_mult,
  input  logic [SHIFT_WIDTH-1:0]   cfg_shift,
  input  logic [OUT_WIDTH-1:0]     cfg_zp,
  input  logic                     cfg_relu,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_WIDTH-1:0]     out_data,
  input  logic                     sat_clr,
  output logic [SAT_CNT_WIDTH-1:0] sat_count
);

  localparam int P_WIDTH = ACCUM_WIDTH + MULT_WIDTH;

  // Stage 1: scaled product plus the per-beat configuration.
  logic                       r_s1_valid;
  logic signed [P_WIDTH-1:0]  r_s1_p;
  logic [P_WIDTH-1:0]         r_s1_rnd;
  logic [SHIFT_WIDTH-1:0]     r_s1_shift;
  logic signed [OUT_WIDTH-1:0] r_s1_zp;
  logic                       r_s1_relu;

  // Stage 2: final result and its saturation flag.
  logic                       r_out_valid;
  logic [OUT_WIDTH-1:0]       r_out_data;
  logic                       r_s2_sat;
  logic [SAT_CNT_WIDTH-1:0]   r_sat_count;

  logic                       w_s2_adv;
  logic                       w_accept;
  logic [P_WIDTH-1:0]         w_acc_ext;
  logic [P_WIDTH-1:0]         w_mult_ext;
  logic signed [P_WIDTH-1:0]  w_p;
  logic [P_WIDTH-1:0]         w_rnd;
  logic signed [OUT_WIDTH-1:0] w_q;
  logic                       w_sat;

  assign w_s2_adv = !r_out_valid || out_ready;
  // Gated by rst_n so no beat is offered as accepted while held in reset.
  assign in_ready = rst_n && (!r_s1_valid || w_s2_adv);
  assign w_accept = in_valid && in_ready;

  // Operands widened to the product width so the multiply is exact.
  always_comb begin
    w_acc_ext  = {{MULT_WIDTH{in_acc[ACCUM_WIDTH-1]}}, in_acc};
    w_mult_ext = {{ACCUM_WIDTH{1'b0}}, cfg_mult};
    w_p        = $signed(w_acc_ext) * $signed(w_mult_ext);
    w_rnd      = (cfg_shift == '0) ? '0 : (P_WIDTH'(1) << (cfg_shift - 1'b1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_p     <= '0;
      r_s1_rnd   <= '0;
      r_s1_shift <= '0;
      r_s1_zp    <= '0;
      r_s1_relu  <= 1'b0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_accept) begin
        r_s1_p     <= w_p;
        r_s1_rnd   <= w_rnd;
        r_s1_shift <= cfg_shift;
        r_s1_zp    <= cfg_zp;
        r_s1_relu  <= cfg_relu;
      end
    end
  end

  requant_sat #(
    .OUT_WIDTH   (OUT_WIDTH),
    .P_WIDTH     (P_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH),
    .QMIN        (QMIN),
    .QMAX        (QMAX)
  ) u_requant_sat (
    .i_p     (r_s1_p),
    .i_rnd   (r_s1_rnd),
    .i_shift (r_s1_shift),
    .i_zp    (r_s1_zp),
    .i_relu  (r_s1_relu),
    .o_data  (w_q),
    .o_sat   (w_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_s2_sat    <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_q;
        r_s2_sat   <= w_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_count <= '0;
    end else if (sat_clr) begin
      r_sat_count <= '0;
    end else if (r_out_valid && out_ready && r_s2_sat && (r_sat_count != '1)) begin
      r_sat_count <= r_sat_count + SAT_CNT_WIDTH'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sat_count = r_sat_count;

endmodule
